// File: rtl/wt_dcache_shct_ctrl_if.sv
// wt_dcache_shct_ctrl_if: handshake and table-port bundle for the signature hit counter table controller.
// Ports: flush request, per-port hit requests/accepts, eviction report/accept,
// lookup request/grant/result, single-port counter table access, busy flag.
interface wt_dcache_shct_ctrl_if #(
  parameter int NumPorts = 3,
  parameter int SigWidth = 14
);
  logic                               flush_i;
  logic [NumPorts-1:0]                hit_valid_i;
  logic [NumPorts-1:0][SigWidth-1:0]  hit_sig_i;
  logic [NumPorts-1:0]                hit_ready_o;
  logic                               evict_valid_i;
  logic [SigWidth-1:0]                evict_sig_i;
  logic                               evict_reused_i;
  logic                               evict_ready_o;
  logic                               lookup_req_i;
  logic [SigWidth-1:0]                lookup_sig_i;
  logic                               lookup_gnt_o;
  logic                               lookup_valid_o;
  logic [1:0]                         lookup_result_o;
  logic                               tbl_req_o;
  logic                               tbl_we_o;
  logic [SigWidth-1:0]                tbl_addr_o;
  logic [1:0]                         tbl_wdata_o;
  logic [1:0]                         tbl_rdata_i;
  logic                               busy_o;
  modport slave (
    input  flush_i, hit_valid_i, hit_sig_i, evict_valid_i, evict_sig_i, evict_reused_i,
           lookup_req_i, lookup_sig_i, tbl_rdata_i,
    output hit_ready_o, evict_ready_o, lookup_gnt_o, lookup_valid_o, lookup_result_o,
           tbl_req_o, tbl_we_o, tbl_addr_o, tbl_wdata_o, busy_o
  );
  modport master (
    output flush_i, hit_valid_i, hit_sig_i, evict_valid_i, evict_sig_i, evict_reused_i,
           lookup_req_i, lookup_sig_i, tbl_rdata_i,
    input  hit_ready_o, evict_ready_o, lookup_gnt_o, lookup_valid_o, lookup_result_o,
           tbl_req_o, tbl_we_o, tbl_addr_o, tbl_wdata_o, busy_o
  );
endinterface

// File: rtl/wt_dcache_shct_ctrl.sv
// wt_dcache_shct_ctrl: saturating 2-bit signature hit counter table controller with update queue.
// Ports: clk_i clock, rst_ni async active-low reset, bus (slave) carrying flush, hit/evict
// requests into the update FIFO, lookup request/result and the single-port table access.
module wt_dcache_shct_ctrl #(
  parameter int NumPorts = 3,
  parameter int SigWidth = 14,
  parameter int QDepth   = 4
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  wt_dcache_shct_ctrl_if.slave bus
);
  localparam int AW = $clog2(QDepth);
  localparam int RW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam logic [1:0] FLUSH = 2'd0, IDLE = 2'd1, UPD = 2'd2, LKP = 2'd3;
  localparam logic INC = 1'b1, DEC = 1'b0;
  logic [1:0]          state_q, state_d;
  logic [SigWidth-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic                op_q, op_d;
  logic [AW:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [RW-1:0]       rr_q, rr_d, gnt_idx;
  logic [SigWidth-1:0] fsig_q [QDepth];
  logic                fop_q [QDepth];
  logic                fl, full, empty, lkp_gnt, pop, can_enq, hit_any, hit_take, enq, enq_op;
  logic [SigWidth-1:0] enq_sig;
  logic [1:0]          rdata, inc_v, dec_v;
  assign fl      = bus.flush_i;
  assign empty   = wptr_q == rptr_q;
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // a full queue blocks the lookup so the update drains first
  assign lkp_gnt = (state_q == IDLE) && bus.lookup_req_i && !full && !fl;
  assign pop     = (state_q == IDLE) && !empty && !lkp_gnt && !fl;
  // a same-cycle pop frees the slot the new request lands in
  assign can_enq = (state_q != FLUSH) && !fl && (!full || pop);
  // lowest offset from the round-robin pointer wins
  always_comb begin
    gnt_idx = rr_q;
    hit_any = 1'b0;
    for (int k = NumPorts - 1; k >= 0; k--)
      if (bus.hit_valid_i[RW'((int'(rr_q) + k) % NumPorts)]) begin
        gnt_idx = RW'((int'(rr_q) + k) % NumPorts);
        hit_any = 1'b1;
      end
  end
  assign hit_take          = can_enq && !bus.evict_valid_i && hit_any;
  assign bus.hit_ready_o   = hit_take ? (NumPorts'(1) << gnt_idx) : '0;
  assign bus.evict_ready_o = can_enq && bus.evict_valid_i;
  assign bus.lookup_gnt_o  = lkp_gnt;
  assign bus.busy_o        = state_q == FLUSH;
  // reused evictions are acknowledged but never queued
  assign enq     = bus.evict_valid_i ? (can_enq && !bus.evict_reused_i) : hit_take;
  assign enq_sig = bus.evict_valid_i ? bus.evict_sig_i : bus.hit_sig_i[gnt_idx];
  assign enq_op  = bus.evict_valid_i ? DEC : INC;
  assign rr_d    = hit_take ? ((gnt_idx == RW'(NumPorts - 1)) ? '0 : gnt_idx + RW'(1)) : rr_q;
  assign rdata   = bus.tbl_rdata_i;
  assign inc_v   = (rdata == 2'd3) ? 2'd3 : rdata + 2'd1;
  assign dec_v   = (rdata == 2'd0) ? 2'd0 : rdata - 2'd1;
  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    addr_d              = addr_q;
    op_d                = op_q;
    wptr_d              = enq ? wptr_q + 1'b1 : wptr_q;
    rptr_d              = pop ? rptr_q + 1'b1 : rptr_q;
    bus.tbl_req_o       = 1'b0;
    bus.tbl_we_o        = 1'b0;
    bus.tbl_addr_o      = cnt_q;
    bus.tbl_wdata_o     = 2'd3;
    bus.lookup_valid_o  = 1'b0;
    bus.lookup_result_o = 2'd0;
    if (fl) begin
      state_d = FLUSH;
      cnt_d   = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else if (state_q == FLUSH) begin
      bus.tbl_req_o = 1'b1;
      bus.tbl_we_o  = 1'b1;
      cnt_d         = cnt_q + 1'b1;
      state_d       = (&cnt_q) ? IDLE : FLUSH;
    end else if (state_q == IDLE) begin
      if (lkp_gnt) begin
        bus.tbl_req_o  = 1'b1;
        bus.tbl_addr_o = bus.lookup_sig_i;
        state_d        = LKP;
      end else if (pop) begin
        bus.tbl_req_o  = 1'b1;
        bus.tbl_addr_o = fsig_q[rptr_q[AW-1:0]];
        addr_d         = fsig_q[rptr_q[AW-1:0]];
        op_d           = fop_q[rptr_q[AW-1:0]];
        state_d        = UPD;
      end
    end else if (state_q == UPD) begin
      bus.tbl_req_o   = 1'b1;
      bus.tbl_we_o    = 1'b1;
      bus.tbl_addr_o  = addr_q;
      bus.tbl_wdata_o = op_q ? inc_v : dec_v;
      state_d         = IDLE;
    end else begin
      bus.lookup_valid_o  = 1'b1;
      bus.lookup_result_o = (rdata == 2'd3) ? 2'd0 : (rdata == 2'd0) ? 2'd3 : 2'd2;
      state_d             = IDLE;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FLUSH;
      cnt_q   <= '0;
      addr_q  <= '0;
      op_q    <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rr_q    <= rr_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (enq) begin
      fsig_q[wptr_q[AW-1:0]] <= enq_sig;
      fop_q[wptr_q[AW-1:0]]  <= enq_op;
    end
  end
endmodule
